// File: rtl/fan_ramp_controller.sv
// Multi-level fan speed controller: target level from up/down/direct-load commands,
// applied speed slews one level per RAMP_DIV cycles, PWM duty follows applied speed.
module fan_ramp_controller #(
  parameter int SPEED_W  = 3,
  parameter int RAMP_DIV = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               update,
  input  logic               up,
  input  logic               down,
  input  logic               set_valid,
  input  logic [SPEED_W-1:0] set_level,
  output logic [SPEED_W-1:0] target,
  output logic [SPEED_W-1:0] speed,
  output logic               pwm,
  output logic               ramping,
  output logic               estop
);

  localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [SPEED_W-1:0] MAX      = '1;
  localparam logic [SPEED_W-1:0] PWM_LAST = MAX - 1'b1;
  localparam logic [CW-1:0]      RELOAD   = CW'(RAMP_DIV - 1);

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SPEED_W-1:0] target_q, target_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [SPEED_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic               pwm_q, pwm_d;
  logic               estop_q;
  logic               estop_cmd;
  logic [SPEED_W-1:0] spd_inc, spd_dec;

  assign estop_cmd = update & up & down;
  assign spd_inc   = speed_q + 1'b1;
  assign spd_dec   = speed_q - 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      target_q  <= '0;
      speed_q   <= '0;
      pwm_cnt_q <= '0;
      pwm_q     <= 1'b0;
      estop_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      target_q  <= target_d;
      speed_q   <= speed_d;
      pwm_cnt_q <= pwm_cnt_d;
      pwm_q     <= pwm_d;
      estop_q   <= estop_cmd;
    end
  end

  // Command priority: estop > direct load > step up > step down.
  always_comb begin
    target_d = target_q;
    if (estop_cmd)                               target_d = '0;
    else if (set_valid)                          target_d = set_level;
    else if (update && up && target_q != MAX)    target_d = target_q + 1'b1;
    else if (update && down && target_q != '0)   target_d = target_q - 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    speed_d = speed_q;
    if (estop_cmd) begin
      state_d = IDLE;
      cnt_d   = '0;
      speed_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (target_q > speed_q) begin
            state_d = RAMP_UP;
            cnt_d   = RELOAD;
          end else if (target_q < speed_q) begin
            state_d = RAMP_DOWN;
            cnt_d   = RELOAD;
          end
        end
        RAMP_UP: begin
          // Direction reversal restarts the step interval without stepping.
          if (target_q < speed_q) begin
            state_d = RAMP_DOWN;
            cnt_d   = RELOAD;
          end else if (target_q == speed_q) begin
            state_d = IDLE;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            speed_d = spd_inc;
            cnt_d   = RELOAD;
            if (spd_inc == target_q) state_d = IDLE;
          end
        end
        RAMP_DOWN: begin
          if (target_q > speed_q) begin
            state_d = RAMP_UP;
            cnt_d   = RELOAD;
          end else if (target_q == speed_q) begin
            state_d = IDLE;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            speed_d = spd_dec;
            cnt_d   = RELOAD;
            if (spd_dec == target_q) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // PWM period is MAX cycles so speed=MAX is a constant high.
  always_comb begin
    pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;
    pwm_d     = (pwm_cnt_q < speed_q);
  end

  always_comb begin
    target  = target_q;
    speed   = speed_q;
    pwm     = pwm_q;
    estop   = estop_q;
    ramping = (state_q != IDLE);
  end

endmodule

// File: tb/tb_fan_ramp_controller.sv
// Self-checking bench: directed scenarios plus random commands against a cycle model.
module tb_fan_ramp_controller;

  localparam int SPEED_W  = 3;
  localparam int RAMP_DIV = 4;
  localparam int MAX      = (1 << SPEED_W) - 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               update, up, down, set_valid;
  logic [SPEED_W-1:0] set_level;
  logic [SPEED_W-1:0] target, speed;
  logic               pwm, ramping, estop;

  int total = 0;
  int bad   = 0;

  // Reference state: integer levels, slew direction and cycles left before the next step.
  int m_tgt, m_spd, m_dir, m_left, m_n;
  bit m_pwm, m_est;

  fan_ramp_controller #(.SPEED_W(SPEED_W), .RAMP_DIV(RAMP_DIV)) dut (
    .clk(clk), .reset(reset), .update(update), .up(up), .down(down),
    .set_valid(set_valid), .set_level(set_level),
    .target(target), .speed(speed), .pwm(pwm), .ramping(ramping), .estop(estop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_tgt = 0; m_spd = 0; m_dir = 0; m_left = 0; m_n = 0; m_pwm = 0; m_est = 0;
  endtask

  task automatic model_edge();
    int old_tgt, old_spd, want, nt;
    old_tgt = m_tgt;
    old_spd = m_spd;
    m_pwm = ((m_n % MAX) < old_spd);
    m_n++;
    m_est = update && up && down;
    if (m_est) begin
      m_tgt = 0; m_spd = 0; m_dir = 0; m_left = 0;
      return;
    end
    nt = old_tgt;
    if (set_valid)                  nt = set_level;
    else if (update && up)          nt = (old_tgt < MAX) ? old_tgt + 1 : MAX;
    else if (update && down)        nt = (old_tgt > 0) ? old_tgt - 1 : 0;
    m_tgt = nt;
    want = (old_tgt > old_spd) ? 1 : (old_tgt < old_spd) ? -1 : 0;
    if (m_dir == 0) begin
      if (want != 0) begin m_dir = want; m_left = RAMP_DIV - 1; end
    end else if (want == 0) begin
      m_dir = 0;
    end else if (want != m_dir) begin
      m_dir = want; m_left = RAMP_DIV - 1;
    end else if (m_left > 0) begin
      m_left--;
    end else begin
      m_spd = old_spd + m_dir;
      m_left = RAMP_DIV - 1;
      if (m_spd == old_tgt) m_dir = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
    chk("target", int'(target), m_tgt);
    chk("speed", int'(speed), m_spd);
    chk("pwm", int'(pwm), int'(m_pwm));
    chk("ramping", int'(ramping), int'(m_dir != 0));
    chk("estop", int'(estop), int'(m_est));
  endtask

  task automatic idle_inputs();
    update = 0; up = 0; down = 0; set_valid = 0; set_level = '0;
  endtask

  // Reset is raised mid-cycle and must clear outputs before any clock edge.
  task automatic apply_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_target", int'(target), 0);
    chk("rst_speed", int'(speed), 0);
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_ramping", int'(ramping), 0);
    chk("rst_estop", int'(estop), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic load(input int lvl);
    set_valid = 1; set_level = SPEED_W'(lvl);
    step();
    idle_inputs();
  endtask

  task automatic wait_speed(input int lvl, input int budget);
    int n = 0;
    while (int'(speed) != lvl && n < budget) begin
      step();
      n++;
    end
    chk("wait_speed_timeout", int'(speed), lvl);
  endtask

  initial begin
    int exp, hi;
    reset = 1'b1;
    idle_inputs();
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) step();

    // Ramp up 0 -> 3 with exact step edges
    load(3);
    for (int k = 1; k <= 14; k++) begin
      step();
      exp = (k >= 13) ? 3 : (k >= 9) ? 2 : (k >= 5) ? 1 : 0;
      chk("ramp_up_speed", int'(speed), exp);
      if (k == 13) chk("ramp_up_done", int'(ramping), 0);
    end

    // Reset mid-activity with speed 5, then pwm must stay low
    load(5);
    wait_speed(5, 40);
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      step();
      chk("post_rst_pwm", int'(pwm), 0);
    end

    // Saturation at both ends
    update = 1; down = 1; step(); idle_inputs();
    chk("sat_low", int'(target), 0);
    chk("sat_low_idle", int'(ramping), 0);
    load(7);
    for (int k = 0; k < 3; k++) begin
      update = 1; up = 1; step(); idle_inputs();
      chk("sat_high", int'(target), 7);
    end

    // Reversal from speed 2 heading to 6
    apply_reset();
    load(6);
    wait_speed(2, 40);
    load(0);
    for (int k = 1; k <= 12; k++) begin
      step();
      exp = (k >= 9) ? 0 : (k >= 5) ? 1 : 2;
      chk("reversal_speed", int'(speed), exp);
    end

    // Emergency stop mid-ramp
    load(7);
    wait_speed(4, 40);
    update = 1; up = 1; down = 1; step(); idle_inputs();
    chk("estop_pulse", int'(estop), 1);
    chk("estop_target", int'(target), 0);
    chk("estop_speed", int'(speed), 0);
    chk("estop_ramping", int'(ramping), 0);
    step();
    chk("estop_clear", int'(estop), 0);

    // PWM duty at speed 3 and at MAX
    load(3);
    wait_speed(3, 40);
    repeat (2) step();
    hi = 0;
    for (int k = 0; k < 10 * MAX; k++) begin step(); hi += int'(pwm); end
    chk("duty_3", hi, 30);
    load(7);
    wait_speed(7, 40);
    repeat (2) step();
    hi = 0;
    for (int k = 0; k < 10 * MAX; k++) begin step(); hi += int'(pwm); end
    chk("duty_max", hi, 70);

    // Random command traffic
    for (int k = 0; k < 800; k++) begin
      int r;
      idle_inputs();
      r = $urandom_range(0, 99);
      if (r < 25) begin
        update = 1;
        up = $urandom_range(0, 1);
        down = $urandom_range(0, 9) == 0 ? up : ~up;
      end else if (r < 32) begin
        set_valid = 1;
        set_level = SPEED_W'($urandom_range(0, MAX));
      end else if (r < 34) begin
        update = $urandom_range(0, 1);
        up = 1; down = $urandom_range(0, 1);
        set_valid = 1;
        set_level = SPEED_W'($urandom_range(0, MAX));
      end else if (r < 36) begin
        up = 1; down = $urandom_range(0, 1);
      end
      if ($urandom_range(0, 199) == 0) begin
        idle_inputs();
        apply_reset();
      end else begin
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
